btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Conditions the five raw board push-buttons (center, up, left, right, down) before they reach the hero controller and any menu logic.
- Per channel: 2-flop synchroniser, counter-based debounce, one-cycle press/release pulses, and a typematic auto-repeat FSM.
- Sits directly upstream of hero_ctl in the pclk (65 MHz) domain.
- A lock input suppresses pulses during level reset.

Parameters:
- N_BTN, 5, number of button channels.
- DEBOUNCE_CYCLES, 650000, consecutive cycles a synchronised input must differ from the stable state before the stable state flips (10 ms at 65 MHz); minimum 2.
- REPEAT_DELAY_CYCLES, 26000000, cycles from press pulse to first repeat pulse (400 ms); minimum 2.
- REPEAT_RATE_CYCLES, 6500000, cycles between subsequent repeat pulses (100 ms); minimum 2.

Ports:
- clk, input, 1, pixel clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- btn_in, input, N_BTN, raw asynchronous button levels. Bit order: 0 center, 1 up, 2 left, 3 right, 4 down.
- lock, input, 1, when high, pulses are suppressed and repeat FSMs are forced to IDLE. Debouncing continues.
- btn_level, output, N_BTN, debounced stable level.
- btn_press, output, N_BTN, one-cycle pulse on a debounced 0->1 transition.
- btn_release, output, N_BTN, one-cycle pulse on a debounced 1->0 transition.
- btn_repeat, output, N_BTN, one-cycle pulse: press pulse OR auto-repeat pulse (typematic stream).
- any_pressed, output, 1, OR of btn_level.

Behaviour:
- Reset: sync flops, stable state, counters and all outputs go to 0; FSMs go to IDLE. A button held through reset produces a press after debounce, exactly as a fresh press does.
- Synchroniser: two flops, so there are 2 cycles of latency into the debounce stage.
- Debounce counter:
  - Width $clog2(DEBOUNCE_CYCLES).
  - Increments each cycle while sync != stable; clears to 0 whenever sync == stable.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync != stable, stable flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES leaves stable unchanged.
- Total latency: btn_level changes on edge 2+DEBOUNCE_CYCLES after the first edge sampling the new raw value (held steady).
- Pulses are registered and asserted in the same cycle btn_level changes; each lasts exactly 1 cycle.
- lock:
  - btn_press, btn_release and btn_repeat are gated low while lock=1.
  - btn_level is unaffected.
  - A transition occurring while locked is lost; no deferred pulse is produced when lock drops.
- Repeat FSM (per channel):
  - IDLE: on an ungated press, go to DELAY, cnt=0, btn_repeat=1 that cycle.
  - DELAY: cnt++ each cycle. At cnt==REPEAT_DELAY_CYCLES-1, pulse btn_repeat, cnt=0, go to REPEAT.
  - REPEAT: cnt++ each cycle. At cnt==REPEAT_RATE_CYCLES-1, pulse btn_repeat and set cnt=0.
  - DELAY/REPEAT: stable==0 or lock==1 returns to IDLE with cnt=0; no pulse that cycle.
- Repeat counter width: $clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)).
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses; no priority is applied here (priority stays in hero_ctl).
- No wrap-around is possible: counters clear on match before reaching their maximum.

Decomposition:
- Shared header btn_defs.vh holds:
  - localparams BTN_CENTER=0, BTN_UP=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_DOWN=4, N_BTN_DEFAULT=5;
  - FSM state encodings ST_IDLE=2'd0, ST_DELAY=2'd1, ST_REPEAT=2'd2.
- One sub-module, btn_channel: synchroniser, debounce, edge detection and repeat FSM for a single bit, with the same parameters.
- btn_conditioner instantiates N_BTN copies via generate and ORs the levels into any_pressed.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3):
- Reset: hold rst 3 cycles with btn_in=5'b11111 -> all outputs 0 during reset; btn_level=5'b11111 and btn_press=5'b11111 for one cycle on edge 6 after rst falls.
- Glitch rejection: raw up=1 for 3 cycles then 0 -> btn_level[1] stays 0; no pulses. Raw up=1 steady -> btn_level[1]=1 and btn_press[1]=1 for one cycle on edge 6.
- Auto-repeat: hold left -> btn_repeat[2] at press cycle P, P+10, P+13, P+16. Release -> btn_release[2] one cycle, 6 edges after raw fall; no further repeats.
- Lock: assert lock, press right -> btn_level[3]=1, btn_press[3] and btn_repeat[3] stay 0. Drop lock while held -> no press pulse and no repeats until release/re-press.
- Lock mid-repeat: lock=1 for 1 cycle at P+11 -> FSM to IDLE; no repeat at P+13 or later while held.
- Simultaneous: up and down pressed on the same cycle -> btn_press=5'b10010 in a single cycle; any_pressed=1 until both are released.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: channel indices, repeat FSM encoding, sizing helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   BTN_* channel indices  - bit positions of each board button inside btn_in and the output vectors
//   N_BTN_DEFAULT          - default channel count
//   rpt_state_e            - typematic repeat FSM state encoding
//   max_int / cnt_width    - elaboration-time helpers for sizing counters
package btn_conditioner_pkg;

   // Bit positions of the board buttons inside every N_BTN-wide vector.
   localparam int BTN_CENTER    = 0;
   localparam int BTN_UP        = 1;
   localparam int BTN_LEFT      = 2;
   localparam int BTN_RIGHT     = 3;
   localparam int BTN_DOWN      = 4;
   localparam int N_BTN_DEFAULT = 5;

   // Typematic repeat FSM states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rpt_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter width able to hold 0..n-1. Never returns less than one bit, so a
   // terminal count of 1 (n == 2) still gets a real register.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, counter debounce, press/release edge pulses, typematic repeat FSM.
// Latency: level/press/release update on edge 2+DEBOUNCE_CYCLES after a steady raw change; all outputs registered.
// Backpressure: none; pulses are single-cycle and unconditional, gated only by lock.
//
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   btn_raw     - raw asynchronous button level
//   lock        - suppresses press/release/repeat pulses and parks the repeat FSM in IDLE
//   ch_level    - debounced stable level
//   ch_press    - one-cycle pulse on a debounced 0->1 transition
//   ch_release  - one-cycle pulse on a debounced 1->0 transition
//   ch_repeat   - one-cycle pulse: the press itself plus the typematic auto-repeat stream
module btn_channel
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = 650000,
   parameter int REPEAT_DELAY_CYCLES = 26000000,
   parameter int REPEAT_RATE_CYCLES  = 6500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic lock,
   output logic ch_level,
   output logic ch_press,
   output logic ch_release,
   output logic ch_repeat
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam int RP_W = cnt_width(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYCLES - 1);

   // Synchroniser
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   // Debounce
   logic            stable_q, stable_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            rise;
   logic            fall;

   // Registered pulses
   logic press_q,   press_d;
   logic release_q, release_d;
   logic repeat_q,  repeat_d;

   // Repeat FSM
   rpt_state_e      state_q, state_d;
   logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
   logic            rpt_hold;   // button still down and not locked after this edge

   // ------------------------------------------------------------------
   // Synchroniser and debounce
   // ------------------------------------------------------------------
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
   end

   // The counter only advances while the synchronised input disagrees with
   // the stable state; any agreement clears it, so a glitch shorter than
   // DEBOUNCE_CYCLES never reaches the terminal count. The counter clears on
   // the flip itself, so it can never wrap.
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      rise     = 1'b0;
      fall     = 1'b0;
      if (sync2_q != stable_q) begin
         if (db_cnt_q == DB_LAST) begin
            stable_d = sync2_q;
            rise     = sync2_q;
            fall     = ~sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   // Pulses are registered alongside stable_q so they line up with the
   // level change. A transition seen while locked is simply dropped.
   always_comb begin
      press_d   = rise & ~lock;
      release_d = fall & ~lock;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         stable_q  <= 1'b0;
         db_cnt_q  <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         stable_q  <= stable_d;
         db_cnt_q  <= db_cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // ------------------------------------------------------------------
   // Repeat FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rp_cnt_q <= '0;
         repeat_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rp_cnt_q <= rp_cnt_d;
         repeat_q <= repeat_d;
      end
   end

   // Judged against the level the button will have after this edge, so the
   // cycle that shows the release never also shows a repeat pulse.
   always_comb begin
      rpt_hold = stable_d & ~lock;
   end

   // ------------------------------------------------------------------
   // Repeat FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      rp_cnt_d = rp_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rise && !lock) begin
               state_d  = ST_DELAY;
               rp_cnt_d = '0;
            end
         end
         ST_DELAY: begin
            if (!rpt_hold) begin
               state_d  = ST_IDLE;
               rp_cnt_d = '0;
            end else if (rp_cnt_q == DELAY_LAST) begin
               state_d  = ST_REPEAT;
               rp_cnt_d = '0;
            end else begin
               rp_cnt_d = rp_cnt_q + RP_W'(1);
            end
         end
         ST_REPEAT: begin
            if (!rpt_hold) begin
               state_d  = ST_IDLE;
               rp_cnt_d = '0;
            end else if (rp_cnt_q == RATE_LAST) begin
               rp_cnt_d = '0;
            end else begin
               rp_cnt_d = rp_cnt_q + RP_W'(1);
            end
         end
         default: begin
            state_d  = ST_IDLE;
            rp_cnt_d = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Repeat FSM: output
   // ------------------------------------------------------------------
   always_comb begin
      repeat_d = 1'b0;
      case (state_q)
         ST_IDLE:   repeat_d = rise & ~lock;
         ST_DELAY:  repeat_d = rpt_hold & (rp_cnt_q == DELAY_LAST);
         ST_REPEAT: repeat_d = rpt_hold & (rp_cnt_q == RATE_LAST);
         default:   repeat_d = 1'b0;
      endcase
   end

   assign ch_level   = stable_q;
   assign ch_press   = press_q;
   assign ch_release = release_q;
   assign ch_repeat  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw board push-buttons: synchronise, debounce, edge pulses and typematic repeat per channel.
// Latency: 2+DEBOUNCE_CYCLES edges from a steady raw change to level/press/release; any_pressed follows btn_level.
// Backpressure: none; every output pulse lasts one cycle and is never held or queued.
//
// Ports:
//   clk, rst     - rising-edge pixel clock, synchronous active-high reset
//   btn_in       - raw button levels (0 center, 1 up, 2 left, 3 right, 4 down)
//   lock         - gates all pulses low and resets repeat FSMs; debouncing keeps running
//   btn_level    - debounced levels
//   btn_press    - debounced 0->1 pulses
//   btn_release  - debounced 1->0 pulses
//   btn_repeat   - press pulse plus auto-repeat pulses
//   any_pressed  - OR of btn_level
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int N_BTN               = N_BTN_DEFAULT,
   parameter int DEBOUNCE_CYCLES     = 650000,
   parameter int REPEAT_DELAY_CYCLES = 26000000,
   parameter int REPEAT_RATE_CYCLES  = 6500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   input  logic             lock,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat,
   output logic             any_pressed
);

   // Channels are fully independent; simultaneous presses give simultaneous
   // pulses and any arbitration is left to the consumer.
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
         .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .btn_raw    (btn_in[i]),
         .lock       (lock),
         .ch_level   (btn_level[i]),
         .ch_press   (btn_press[i]),
         .ch_release (btn_release[i]),
         .ch_repeat  (btn_repeat[i])
      );
   end

   assign any_pressed = |btn_level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a behavioural model pushes the expected outputs of each edge into a queue,
// and a monitor pops and compares them against the DUT one step after that edge.
module tb_btn_conditioner;
   import btn_conditioner_pkg::*;

   localparam int NB = N_BTN_DEFAULT;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   logic          clk;
   logic          rst;
   logic [NB-1:0] btn_in;
   logic          lock;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
   logic          any_pressed;

   btn_conditioner #(
      .N_BTN               (NB),
      .DEBOUNCE_CYCLES     (DB),
      .REPEAT_DELAY_CYCLES (RD),
      .REPEAT_RATE_CYCLES  (RR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .lock        (lock),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_repeat  (btn_repeat),
      .any_pressed (any_pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NB-1:0] level;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic [NB-1:0] rpt;
      logic          any;
   } out_t;

   out_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Observations used by the directed checks.
   int   left_rep_t[$];
   int   simul_cnt;
   int   right_pulse_cnt;

   task automatic chk(input string nm, input logic [NB-1:0] got, input logic [NB-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, want);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model. Rules:
   //  * the synchronised sample seen after edge n is the raw value sampled at edge n-1;
   //  * the level flips at an edge once the last DB synchronised samples all disagree with it;
   //  * press/release pulse with the flip unless lock is sampled high;
   //  * a typematic burst starts at an unlocked press (cycle p) and pulses at p, p+RD, p+RD+RR, ...
   //    until the level falls or lock is seen, whichever cancels it first.
   // ------------------------------------------------------------------
   logic [NB-1:0] m_level;
   logic [NB-1:0] m_raw_prev;
   bit            m_win[NB][$];
   bit            m_active[NB];
   int            m_p[NB];
   bit            m_flip, m_rise, m_fall, m_all_diff;
   int            m_k;
   out_t          m_e;

   always @(posedge clk) begin
      cyc++;
      m_e = '0;
      if (rst) begin
         m_level    = '0;
         m_raw_prev = '0;
         for (int c = 0; c < NB; c++) begin
            m_win[c].delete();
            m_active[c] = 1'b0;
         end
      end else begin
         for (int c = 0; c < NB; c++) begin
            m_flip = 1'b0;
            if (m_win[c].size() == DB) begin
               m_all_diff = 1'b1;
               foreach (m_win[c][i]) if (m_win[c][i] == m_level[c]) m_all_diff = 1'b0;
               m_flip = m_all_diff;
            end
            m_rise = m_flip && !m_level[c];
            m_fall = m_flip &&  m_level[c];
            if (m_flip) m_level[c] = ~m_level[c];
            m_e.press[c] = m_rise && !lock;
            m_e.rel[c]   = m_fall && !lock;

            m_win[c].push_back(m_raw_prev[c]);
            if (m_win[c].size() > DB) void'(m_win[c].pop_front());

            if (m_rise) begin
               if (!lock) begin
                  m_active[c] = 1'b1;
                  m_p[c]      = cyc;
                  m_e.rpt[c]  = 1'b1;
               end
            end else if (m_active[c]) begin
               if (lock || !m_level[c]) begin
                  m_active[c] = 1'b0;
               end else begin
                  m_k = cyc - m_p[c];
                  if (m_k == RD || (m_k > RD && (m_k - RD) % RR == 0)) m_e.rpt[c] = 1'b1;
               end
            end
         end
         m_raw_prev = btn_in;
      end
      m_e.level = m_level;
      m_e.any   = |m_level;
      exp_q.push_back(m_e);
   end

   // ------------------------------------------------------------------
   // Monitor: compares one step after each edge.
   // ------------------------------------------------------------------
   out_t mon_e;

   always @(posedge clk) begin
      #1;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty cyc=%0d got=none want=entry", cyc);
      end else begin
         mon_e = exp_q.pop_front();
         chk("level",   btn_level,   mon_e.level);
         chk("press",   btn_press,   mon_e.press);
         chk("release", btn_release, mon_e.rel);
         chk("repeat",  btn_repeat,  mon_e.rpt);
         chk("any",     {{(NB-1){1'b0}}, any_pressed}, {{(NB-1){1'b0}}, mon_e.any});
      end
      if (btn_repeat[BTN_LEFT] === 1'b1) left_rep_t.push_back(cyc);
      if (btn_press === 5'b10010) simul_cnt++;
      if (btn_press[BTN_RIGHT] === 1'b1 || btn_repeat[BTN_RIGHT] === 1'b1) right_pulse_cnt++;
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic drive(input logic [NB-1:0] b, input logic l, input logic r, input int n);
      btn_in = b;
      lock   = l;
      rst    = r;
      repeat (n) @(negedge clk);
   endtask

   logic [NB-1:0] rnd_b;
   logic          rnd_l, rnd_r;

   initial begin
      // Reset with every button already held, then release.
      drive(5'b11111, 1'b0, 1'b1, 3);
      drive(5'b11111, 1'b0, 1'b0, 10);
      drive(5'b00000, 1'b0, 1'b0, 10);

      // Glitch shorter than the debounce window, then a real press of up.
      drive(5'b00010, 1'b0, 1'b0, 3);
      drive(5'b00000, 1'b0, 1'b0, 8);
      drive(5'b00010, 1'b0, 1'b0, 10);
      drive(5'b00000, 1'b0, 1'b0, 10);

      // Auto-repeat on left: pulses at P, P+10, P+13, P+16, ...
      left_rep_t.delete();
      drive(5'b00100, 1'b0, 1'b0, 30);
      drive(5'b00000, 1'b0, 1'b0, 12);
      chk_int("autorep_count_min", (left_rep_t.size() >= 4) ? 1 : 0, 1);
      if (left_rep_t.size() >= 4) begin
         chk_int("autorep_first_gap",  left_rep_t[1] - left_rep_t[0], RD);
         chk_int("autorep_second_gap", left_rep_t[2] - left_rep_t[1], RR);
         chk_int("autorep_third_gap",  left_rep_t[3] - left_rep_t[2], RR);
      end

      // Press right while locked, then unlock while still held.
      right_pulse_cnt = 0;
      drive(5'b01000, 1'b1, 1'b0, 10);
      drive(5'b01000, 1'b0, 1'b0, 20);
      drive(5'b00000, 1'b0, 1'b0, 10);
      chk_int("lock_right_pulses", right_pulse_cnt, 0);

      // One locked cycle in the middle of a left repeat burst.
      left_rep_t.delete();
      drive(5'b00100, 1'b0, 1'b0, 17);
      drive(5'b00100, 1'b1, 1'b0, 1);
      drive(5'b00100, 1'b0, 1'b0, 15);
      drive(5'b00000, 1'b0, 1'b0, 10);
      chk_int("midlock_rep_count", left_rep_t.size(), 2);
      if (left_rep_t.size() == 2) chk_int("midlock_rep_gap", left_rep_t[1] - left_rep_t[0], RD);

      // Up and down pressed together, released one after another.
      simul_cnt = 0;
      drive(5'b10010, 1'b0, 1'b0, 12);
      drive(5'b10000, 1'b0, 1'b0, 10);
      drive(5'b00000, 1'b0, 1'b0, 10);
      chk_int("simul_press_cycles", simul_cnt, 1);

      // Random segments, including lock and occasional reset.
      for (int s = 0; s < 90; s++) begin
         rnd_b = NB'($urandom);
         rnd_l = ($urandom_range(0, 5) == 0);
         rnd_r = ($urandom_range(0, 39) == 0);
         drive(rnd_b, rnd_l, rnd_r, $urandom_range(1, 30));
      end
      drive(5'b00000, 1'b0, 1'b0, 12);

      chk_int("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
